// File: rtl/gshare_direction_predictor_pkg.sv
// Shared types and helpers for the gshare direction predictor.
package gshare_direction_predictor_pkg;

  // Table-clear FSM: INIT sweeps the PHT once, RUN is normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

  // Weakly-not-taken counter value for a counter of ctr_w bits (ctr_w <= 4).
  function automatic logic [3:0] weak_not_taken(input int ctr_w);
    return 4'((1 << (ctr_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/gshare_direction_predictor_if.sv
// Fetch/branch-unit signal bundle for the gshare predictor, plus debug taps.
//
// Handshake semantics: there is no backpressure. fetch_req, fetch_id_assigned
// and br_valid are single-cycle valid strobes; each qualifies its companion
// fields in the same cycle only and the predictor always accepts them.
interface gshare_direction_predictor_if #(
  parameter int PHT_ADDR_W = 10,
  parameter int HIST_W     = 8,
  parameter int CTR_W      = 2,
  parameter int ID_W       = 3
);
  import gshare_direction_predictor_pkg::*;

  logic                  fetch_req;
  logic [31:0]           fetch_pc;
  logic                  fetch_id_assigned;
  logic [ID_W-1:0]       fetch_id;
  logic                  fetch_is_branch;
  logic                  predict_taken;
  logic                  predict_valid;
  logic                  init_busy;
  logic                  br_valid;
  logic [ID_W-1:0]       br_id;
  logic                  br_is_branch;
  logic                  br_taken;
  logic                  br_mispredict;
  init_state_e           dbg_state;
  logic [HIST_W-1:0]     dbg_ghr;
  logic [PHT_ADDR_W-1:0] dbg_init_ctr;
  logic [CTR_W-1:0]      dbg_ctr;

  modport master (
    output fetch_req, fetch_pc, fetch_id_assigned, fetch_id, fetch_is_branch,
    output br_valid, br_id, br_is_branch, br_taken, br_mispredict,
    input  predict_taken, predict_valid, init_busy,
    input  dbg_state, dbg_ghr, dbg_init_ctr, dbg_ctr
  );

  modport slave (
    input  fetch_req, fetch_pc, fetch_id_assigned, fetch_id, fetch_is_branch,
    input  br_valid, br_id, br_is_branch, br_taken, br_mispredict,
    output predict_taken, predict_valid, init_busy,
    output dbg_state, dbg_ghr, dbg_init_ctr, dbg_ctr
  );

endinterface

// File: rtl/gshare_direction_predictor_sat_counter_next.sv
// Next value of a saturating up/down counter: no wrap at either end.
module gshare_direction_predictor_sat_counter_next #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Step toward taken/not-taken, holding at the extremes.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_direction_predictor.sv
// gshare direction predictor: PHT indexed by PC xor global history, with
// per-ID checkpoints of {index, counter, history} for update and repair.
module gshare_direction_predictor
  import gshare_direction_predictor_pkg::*;
#(
  parameter int PHT_ADDR_W = 10,
  parameter int HIST_W     = 8,
  parameter int CTR_W      = 2,
  parameter int ID_W       = 3
) (
  input logic clk,
  input logic rst,
  gshare_direction_predictor_if.slave bus
);

  localparam int PHT_DEPTH  = 1 << PHT_ADDR_W;
  localparam int CKPT_DEPTH = 1 << ID_W;
  localparam logic [PHT_ADDR_W-1:0] INIT_LAST = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(weak_not_taken(CTR_W));

  typedef struct packed {
    logic [PHT_ADDR_W-1:0] idx;
    logic [CTR_W-1:0]      ctr;
    logic [HIST_W-1:0]     ghr;
  } ckpt_t;

  init_state_e           state_q, state_d;
  logic [PHT_ADDR_W-1:0] init_ctr_q;
  logic                  busy, pred_valid, init_we;

  logic [HIST_W-1:0]     ghr_q, ghr_d;
  logic [PHT_ADDR_W-1:0] ghr_ext, fetch_idx, idx_q;
  logic [CTR_W-1:0]      ctr_q;
  logic                  pred_taken;

  logic [CTR_W-1:0]      pht_mem [PHT_DEPTH];
  ckpt_t                 ckpt_mem [CKPT_DEPTH];
  ckpt_t                 ckpt_rd, ckpt_wr;

  logic [CTR_W-1:0]      ctr_upd;
  logic                  upd_we, pht_we;
  logic [PHT_ADDR_W-1:0] pht_waddr;
  logic [CTR_W-1:0]      pht_wdata;
  logic                  spec_shift, repair;
  logic                  unused_pc_bits;

  // Shift one outcome into the low end of a history value.
  function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h,
                                                 input logic b);
    logic [HIST_W:0] t;
    t = {h, b};
    return t[HIST_W-1:0];
  endfunction

  // FSM state register; reset restarts the table clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // FSM next state: leave INIT once the last entry has been written.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_ctr_q == INIT_LAST) state_d = ST_RUN;
  end

  // FSM outputs.
  always_comb begin
    busy       = (state_q == ST_INIT);
    pred_valid = (state_q == ST_RUN);
    init_we    = busy;
  end

  // Clear pointer walks the whole PHT while in INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         init_ctr_q <= '0;
    else if (busy)    init_ctr_q <= init_ctr_q + 1'b1;
  end

  // Fetch index: PC word bits xor zero-extended history of this cycle.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[HIST_W-1:0]    = ghr_q;
    fetch_idx              = bus.fetch_pc[PHT_ADDR_W+1:2] ^ ghr_ext;
  end

  assign unused_pc_bits = ^{bus.fetch_pc[31:PHT_ADDR_W+2], bus.fetch_pc[1:0]};

  // Synchronous PHT read; index and counter are held until the next fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      ctr_q <= '0;
    end else if (bus.fetch_req) begin
      idx_q <= fetch_idx;
      ctr_q <= pht_mem[fetch_idx];
    end
  end

  assign pred_taken = ctr_q[CTR_W-1] & pred_valid;

  // Resolution path: asynchronous checkpoint read and saturating update.
  assign ckpt_rd = ckpt_mem[bus.br_id];

  gshare_direction_predictor_sat_counter_next #(.CTR_W(CTR_W)) u_sat (
    .ctr      (ckpt_rd.ctr),
    .taken    (bus.br_taken),
    .ctr_next (ctr_upd)
  );

  assign upd_we = bus.br_valid & bus.br_is_branch & ~busy & (ctr_upd != ckpt_rd.ctr);

  // Single PHT write port: the clear sweep owns it during INIT.
  always_comb begin
    pht_we    = upd_we;
    pht_waddr = ckpt_rd.idx;
    pht_wdata = ctr_upd;
    if (init_we) begin
      pht_we    = 1'b1;
      pht_waddr = init_ctr_q;
      pht_wdata = CTR_WNT;
    end
  end

  // PHT storage (not reset; cleared by the INIT sweep).
  always_ff @(posedge clk) begin
    if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
  end

  assign ckpt_wr = '{idx: idx_q, ctr: ctr_q, ghr: ghr_q};

  // Checkpoint storage, overwritten whenever an ID is reallocated.
  always_ff @(posedge clk) begin
    if (bus.fetch_id_assigned) ckpt_mem[bus.fetch_id] <= ckpt_wr;
  end

  // History next value: repair wins over a speculative shift.
  always_comb begin
    repair     = bus.br_valid & bus.br_mispredict & pred_valid;
    spec_shift = bus.fetch_id_assigned & bus.fetch_is_branch & pred_valid;
    ghr_d      = ghr_q;
    if (repair) begin
      ghr_d = bus.br_is_branch ? shift_in(ckpt_rd.ghr, bus.br_taken) : ckpt_rd.ghr;
    end else if (spec_shift) begin
      ghr_d = shift_in(ghr_q, pred_taken);
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign bus.predict_taken = pred_taken;
  assign bus.predict_valid = pred_valid;
  assign bus.init_busy     = busy;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_ghr       = ghr_q;
  assign bus.dbg_init_ctr  = init_ctr_q;
  assign bus.dbg_ctr       = ctr_q;

endmodule
